// File: rtl/ula_control_fsm.sv
// ula_control_fsm
//   Multi-cycle control unit for the shared ULA/register-file datapath.
//   It captures a 9-bit instruction from DIN when Run is high in T0. It then
//   steps through T1..T3, driving one datapath action per clock, and pulses
//   Done when the instruction retires.
//
// Ports
//   Clock      in   rising-edge clock
//   Resetn     in   asynchronous active-low reset
//   Run        in   start request, sampled only in T0
//   DIN        in   instruction word (T0) / immediate source (mvi, T1)
//   IRin       out  instruction-register load strobe
//   Rin        out  one-hot register write enable R0..R7
//   Rout       out  one-hot register bus drive select R0..R7
//   Ain        out  load ULA operand register A from the bus
//   Gin        out  load result register G from the ULA
//   Gout       out  G drives the bus
//   DINout     out  DIN drives the bus
//   sinal_ULA  out  ULA op: 000 add, 001 sub, 010 or, 011 slt, 100 sll, 101 srl
//   Done       out  one-cycle instruction retire strobe
//   Busy       out  high in every state other than T0
module ula_control_fsm #(
  parameter int DATA_W = 16,
  parameter int IR_LSB = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              DINout,
  output logic [2:0]        sinal_ULA,
  output logic              Done,
  output logic              Busy
);

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  state_t     state;
  state_t     state_next;
  logic [8:0] ir;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] sel_x;
  logic [7:0] sel_y;
  logic       din_unused;

  assign op    = ir[8:6];
  assign rx    = ir[5:3];
  assign ry    = ir[2:0];
  assign sel_x = 8'b0000_0001 << rx;
  assign sel_y = 8'b0000_0001 << ry;

  // Only the instruction field of DIN is consumed here; the rest goes to the bus.
  assign din_unused = ^DIN;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && Run) begin
        ir <= DIN[IR_LSB +: 9];
      end
    end
  end

  always_comb begin
    state_next = state;
    IRin       = 1'b0;
    Rin        = '0;
    Rout       = '0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    sinal_ULA  = '0;
    Done       = 1'b0;
    Busy       = (state != T0);

    case (state)
      T0: begin
        // Gated by Resetn so that every output stays low while reset is held.
        IRin = Run && Resetn;
        if (Run) begin
          state_next = T1;
        end
      end
      T1: begin
        if (op == OP_MV) begin
          Rout       = sel_y;
          Rin        = sel_x;
          Done       = 1'b1;
          state_next = T0;
        end else if (op == OP_MVI) begin
          DINout     = 1'b1;
          Rin        = sel_x;
          Done       = 1'b1;
          state_next = T0;
        end else begin
          Rout       = sel_x;
          Ain        = 1'b1;
          state_next = T2;
        end
      end
      T2: begin
        Rout       = sel_y;
        Gin        = 1'b1;
        // ULA opcodes start at 010, so the ULA code is the op offset from add.
        sinal_ULA  = op - 3'b010;
        state_next = T3;
      end
      T3: begin
        Gout       = 1'b1;
        Rin        = sel_x;
        Done       = 1'b1;
        state_next = T0;
      end
      default: begin
        state_next = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_ula_control_fsm.sv
// tb_ula_control_fsm
//   Randomized self-checking bench for ula_control_fsm. A per-instruction
//   reference model builds the expected cycle-by-cycle output sequence from the
//   instruction's op/rx/ry. Observed outputs are collected per cycle and
//   compared in each scenario task. A monitor checks bus exclusivity and that
//   Rin is at most one-hot on every cycle.
module tb_ula_control_fsm;

  localparam int DATA_W = 16;
  localparam int IR_LSB = 0;

  logic              Clock  = 1'b0;
  logic              Resetn = 1'b1;
  logic              Run    = 1'b0;
  logic [DATA_W-1:0] DIN    = '0;
  logic              IRin;
  logic [7:0]        Rin;
  logic [7:0]        Rout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              DINout;
  logic [2:0]        sinal_ULA;
  logic              Done;
  logic              Busy;

  int checks = 0;
  int errors = 0;

  logic [25:0] act;
  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];

  ula_control_fsm #(.DATA_W(DATA_W), .IR_LSB(IR_LSB)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .DINout(DINout), .sinal_ULA(sinal_ULA),
    .Done(Done), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  assign act = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, sinal_ULA, Done, Busy};

  function automatic logic [25:0] vec(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic ain,
                                      input logic gin, input logic gout,
                                      input logic dinout, input logic [2:0] alu,
                                      input logic done, input logic busy);
    return {irin, rin, rout, ain, gin, gout, dinout, alu, done, busy};
  endfunction

  function automatic logic [2:0] alu_code(input logic [2:0] op);
    case (op)
      3'd2:    return 3'd0; // add
      3'd3:    return 3'd1; // sub
      3'd4:    return 3'd2; // or
      3'd5:    return 3'd3; // slt
      3'd6:    return 3'd4; // sll
      default: return 3'd5; // srl
    endcase
  endfunction

  // Expected per-cycle outputs, starting with the T0 capture cycle.
  function automatic void model(input logic [8:0] ir);
    logic [2:0] op = ir[8:6];
    logic [7:0] wx = 8'd1 << ir[5:3];
    logic [7:0] wy = 8'd1 << ir[2:0];
    exp_q.delete();
    exp_q.push_back(vec(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    if (op == 3'd0) begin
      exp_q.push_back(vec(1'b0, wx, wy, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1));
    end else if (op == 3'd1) begin
      exp_q.push_back(vec(1'b0, wx, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(vec(1'b0, '0, wx, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1));
      exp_q.push_back(vec(1'b0, '0, wy, 1'b0, 1'b1, 1'b0, 1'b0, alu_code(op), 1'b0, 1'b1));
      exp_q.push_back(vec(1'b0, wx, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1));
    end
  endfunction

  // Runs one instruction from its T0 cycle, recording outputs each cycle.
  // keep: Run level during the sequence; noise: random Run/DIN after T0.
  task automatic drive_instr(input logic [8:0] ir, input bit keep, input bit noise);
    int steps = (ir[8:7] == 2'b00) ? 1 : 3;
    obs_q.delete();
    Run = 1'b1;
    DIN = DATA_W'($urandom);
    DIN[IR_LSB +: 9] = ir;
    @(negedge Clock);
    obs_q.push_back(act);
    @(posedge Clock); #1;
    for (int k = 0; k < steps; k++) begin
      if (noise) begin
        Run = 1'($urandom);
        DIN = DATA_W'($urandom);
      end else begin
        Run = keep;
      end
      @(negedge Clock);
      obs_q.push_back(act);
      @(posedge Clock); #1;
    end
  endtask

  always @(negedge Clock) begin
    checks++;
    if ($countones(Rout) + int'(Gout) + int'(DINout) > 1 || $countones(Rin) > 1) begin
      errors++;
      $display("FAIL bus_excl t=%0t: Rout=%b Gout=%b DINout=%b Rin=%b, need <=1 bus driver and Rin <=1-hot",
               $time, Rout, Gout, DINout, Rin);
    end
  end

  task automatic test_idle(input int n);
    Run = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL idle[%0d]: got %b, need %b", i, act, 26'b0);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = DATA_W'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b, need %b", i, act, 26'b0);
      end
    end
    Run = 1'b0;
    #2 Resetn = 1'b1;
    @(posedge Clock); #1;
    test_idle(2);
  endtask

  task automatic test_single(input string name, input logic [8:0] ir);
    model(ir);
    drive_instr(ir, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d cycles, need %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s[cyc %0d]: got %b, need %b", name, i, obs_q[i], exp_q[i]);
      end
    end
    test_idle(1);
  endtask

  task automatic test_back_to_back();
    logic [8:0] prog[2] = '{9'b111_000_001, 9'b101_011_100};
    for (int p = 0; p < 2; p++) begin
      model(prog[p]);
      drive_instr(prog[p], (p == 0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b%0d[cyc %0d]: got %b, need %b", p, i, obs_q[i], exp_q[i]);
        end
      end
    end
    test_idle(1);
  endtask

  task automatic test_run_ignored();
    logic [8:0] prog[3] = '{9'b011_001_110, 9'b001_100_000, 9'b000_010_111};
    for (int p = 0; p < 3; p++) begin
      model(prog[p]);
      drive_instr(prog[p], 1'b0, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL run_ignored%0d[cyc %0d]: got %b, need %b", p, i, obs_q[i], exp_q[i]);
        end
      end
    end
    test_idle(1);
  endtask

  task automatic test_reset_mid();
    logic [8:0] ir = 9'b010_011_100;
    model(ir);
    Run = 1'b1;
    DIN = DATA_W'(ir);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_pre[cyc %0d]: got %b, need %b", i, act, exp_q[i]);
      end
      if (i < 2) begin
        @(posedge Clock); #1;
        Run = 1'b0;
      end
    end
    // Now in T2 of the add, mid-cycle.
    #2 Resetn = 1'b0;
    Run = 1'b1;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got %b, need %b", act, 26'b0);
    end
    @(negedge Clock);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL rst_mid_hold: got %b, need %b", act, 26'b0);
    end
    Run = 1'b0;
    #1 Resetn = 1'b1;
    @(posedge Clock); #1;
    test_idle(2);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [8:0] ir = 9'($urandom);
      bit keep  = 1'($urandom);
      bit noise = ($urandom_range(0, 3) == 0);
      model(ir);
      drive_instr(ir, keep, noise);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d ir=%b[cyc %0d]: got %b, need %b", t, ir, i, obs_q[i], exp_q[i]);
        end
      end
      if (!keep && $urandom_range(0, 1) == 1) begin
        test_idle($urandom_range(1, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single("mvi_r2", 9'b001_010_000);
    test_single("mv_r5_r3", 9'b000_101_011);
    test_single("sub_r1_r6", 9'b011_001_110);
    test_single("sub_r4_r4", 9'b011_100_100);
    test_back_to_back();
    test_run_ignored();
    test_reset_mid();
    test_single("mvi_after_rst", 9'b001_111_000);
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
